// File: rtl/tl45_wb_pkg.sv
// Shared Wishbone bus definitions for the tl45 core: bus widths, arbiter states
// and master identifiers used by the arbiter, memory stage and fetch unit.
package tl45_wb_pkg;

  localparam int WB_ADDR_W = 30;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    GNT_A,
    GNT_B,
    ERR_DRAIN
  } arb_state_t;

  typedef enum logic {
    MASTER_A,
    MASTER_B
  } master_t;

endpackage

// File: rtl/tl45_wb_watchdog.sv
// Bus watchdog: counts enabled cycles and pulses expired on the cycle the count
// reaches TIMEOUT_CYCLES-1; any clear restarts the count from zero.
module tl45_wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = enable && !clear && (count == LAST);

  // The count restarts after firing so a stuck enable cannot re-fire early.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/tl45_wb_arbiter.sv
// Two-master (memory stage A, fetch B) to one-slave pipelined Wishbone arbiter
// with round-robin grant locked for the whole CYC and a hung-slave watchdog.
module tl45_wb_arbiter
  import tl45_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 1023,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_a_cyc,
  input  logic                 i_a_stb,
  input  logic                 i_a_we,
  input  logic [WB_ADDR_W-1:0] i_a_addr,
  input  logic [WB_DATA_W-1:0] i_a_data,
  input  logic [WB_SEL_W-1:0]  i_a_sel,
  output logic                 o_a_ack,
  output logic                 o_a_stall,
  output logic                 o_a_err,
  output logic [WB_DATA_W-1:0] o_a_data,
  input  logic                 i_b_cyc,
  input  logic                 i_b_stb,
  input  logic                 i_b_we,
  input  logic [WB_ADDR_W-1:0] i_b_addr,
  input  logic [WB_DATA_W-1:0] i_b_data,
  input  logic [WB_SEL_W-1:0]  i_b_sel,
  output logic                 o_b_ack,
  output logic                 o_b_stall,
  output logic                 o_b_err,
  output logic [WB_DATA_W-1:0] o_b_data,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [WB_ADDR_W-1:0] o_wb_addr,
  output logic [WB_DATA_W-1:0] o_wb_data,
  output logic [WB_SEL_W-1:0]  o_wb_sel,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_err,
  input  logic [WB_DATA_W-1:0] i_wb_data
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

  arb_state_t    state;
  master_t       last_grant;
  master_t       owner;
  logic [OW-1:0] outstanding;

  logic granted, sel_a, m_cyc, m_stb, full, has_out;
  logic resp_ack, resp_err, resp, accepted;
  logic wd_enable, wd_clear, expired;

  assign granted  = (state == GNT_A) || (state == GNT_B);
  assign sel_a    = (state == GNT_A);
  assign m_cyc    = sel_a ? i_a_cyc : i_b_cyc;
  assign m_stb    = sel_a ? i_a_stb : i_b_stb;
  assign full     = (outstanding == OUT_MAX);
  assign has_out  = (outstanding != '0);

  // Responses with nothing outstanding are stray and never reach a master.
  assign resp_err = granted && has_out && i_wb_err;
  assign resp_ack = granted && has_out && i_wb_ack && !i_wb_err;
  assign resp     = resp_ack || resp_err;

  assign wd_enable = granted && m_cyc && has_out && !i_wb_ack && !i_wb_err;
  assign wd_clear  = !granted || i_wb_ack || i_wb_err;

  assign o_wb_cyc = granted && m_cyc && !expired;
  assign o_wb_stb = o_wb_cyc && m_stb && !full;
  assign accepted = o_wb_stb && !i_wb_stall;

  tl45_wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .enable  (wd_enable),
    .clear   (wd_clear),
    .expired (expired)
  );

  always_comb begin
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_data = '0;
    o_wb_sel  = '0;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_a_data  = '0;
    o_a_stall = 1'b1;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    o_b_data  = '0;
    o_b_stall = 1'b1;
    if (sel_a) begin
      o_wb_we   = i_a_we;
      o_wb_addr = i_a_addr;
      o_wb_data = i_a_data;
      o_wb_sel  = i_a_sel;
      o_a_ack   = resp_ack;
      o_a_err   = resp_err || expired;
      o_a_data  = i_wb_data;
      o_a_stall = i_wb_stall || full || expired;
    end else if (state == GNT_B) begin
      o_wb_we   = i_b_we;
      o_wb_addr = i_b_addr;
      o_wb_data = i_b_data;
      o_wb_sel  = i_b_sel;
      o_b_ack   = resp_ack;
      o_b_err   = resp_err || expired;
      o_b_data  = i_wb_data;
      o_b_stall = i_wb_stall || full || expired;
    end
  end

  // Arbiter FSM; the grant is held until the winner drops CYC or the watchdog fires.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      last_grant  <= MASTER_B;
      owner       <= MASTER_A;
      outstanding <= '0;
    end else begin
      case (state)
        IDLE: begin
          outstanding <= '0;
          if (i_a_cyc && (!i_b_cyc || last_grant == MASTER_B)) begin
            state <= GNT_A;
            owner <= MASTER_A;
          end else if (i_b_cyc) begin
            state <= GNT_B;
            owner <= MASTER_B;
          end
        end
        GNT_A, GNT_B: begin
          if (expired) begin
            state       <= ERR_DRAIN;
            outstanding <= '0;
          end else if (!m_cyc) begin
            state       <= IDLE;
            last_grant  <= owner;
            outstanding <= '0;
          end else if (accepted && !resp) begin
            outstanding <= outstanding + OW'(1);
          end else if (resp && !accepted) begin
            outstanding <= outstanding - OW'(1);
          end
        end
        ERR_DRAIN: begin
          if ((owner == MASTER_A) ? !i_a_cyc : !i_b_cyc) begin
            state      <= IDLE;
            last_grant <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl45_wb_arbiter.sv
// Directed self-checking bench for tl45_wb_arbiter (TIMEOUT_CYCLES=16, MAX_OUTSTANDING=4).
module tb_tl45_wb_arbiter;

  logic        i_clk, i_reset;
  logic        i_a_cyc, i_a_stb, i_a_we;
  logic [29:0] i_a_addr;
  logic [31:0] i_a_data;
  logic [3:0]  i_a_sel;
  logic        o_a_ack, o_a_stall, o_a_err;
  logic [31:0] o_a_data;
  logic        i_b_cyc, i_b_stb, i_b_we;
  logic [29:0] i_b_addr;
  logic [31:0] i_b_data;
  logic [3:0]  i_b_sel;
  logic        o_b_ack, o_b_stall, o_b_err;
  logic [31:0] o_b_data;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack, i_wb_stall, i_wb_err;
  logic [31:0] i_wb_data;

  int checks = 0;
  int failures = 0;

  tl45_wb_arbiter #(
    .TIMEOUT_CYCLES (16),
    .MAX_OUTSTANDING(4)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
    .i_a_data(i_a_data), .i_a_sel(i_a_sel),
    .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err), .o_a_data(o_a_data),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
    .i_b_data(i_b_data), .i_b_sel(i_b_sel),
    .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err), .o_b_data(o_b_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = '0; i_a_sel = '0;
    i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_addr = '0; i_b_data = '0; i_b_sel = '0;
    i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0; i_wb_data = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_reset = 1'b1;
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 30'h155; i_a_data = 32'h1234_5678; i_a_sel = 4'hF;
    i_wb_ack = 1; i_wb_err = 1; i_wb_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_a_stall, o_b_stall, o_a_ack, o_b_ack, o_a_err, o_b_err} !== 9'b000110000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b exp=000110000",
               {o_wb_cyc, o_wb_stb, o_wb_we, o_a_stall, o_b_stall, o_a_ack, o_b_ack, o_a_err, o_b_err});
    end
    tick();
    checks++;
    if ({o_wb_addr, o_wb_data, o_wb_sel, o_a_data, o_b_data} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_bus got addr=%h data=%h sel=%h adata=%h bdata=%h exp all zero",
               o_wb_addr, o_wb_data, o_wb_sel, o_a_data, o_b_data);
    end
    reset_dut();
  endtask

  task automatic test_a_read();
    reset_dut();
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 30'h0000_0100;
    #1;
    checks++;
    if ({o_a_stall, o_wb_stb} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL a_read_arb_stall got stall,stb=%b exp=10", {o_a_stall, o_wb_stb});
    end
    tick();
    #1;
    checks++;
    if ({o_wb_cyc, o_wb_stb, o_a_stall, o_wb_addr} !== {3'b110, 30'h0000_0100}) begin
      failures++;
      $display("[TB] FAIL a_read_strobe got cyc,stb,stall=%b addr=%h exp 110 addr=100",
               {o_wb_cyc, o_wb_stb, o_a_stall}, o_wb_addr);
    end
    tick();
    i_a_stb = 0; i_wb_ack = 1; i_wb_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({o_a_ack, o_a_err, o_a_data} !== {2'b10, 32'hDEAD_BEEF}) begin
      failures++;
      $display("[TB] FAIL a_read_ack got ack,err=%b data=%h exp 10 DEADBEEF", {o_a_ack, o_a_err}, o_a_data);
    end
    checks++;
    if ({o_b_ack, o_b_err, o_b_stall, o_b_data} !== {3'b001, 32'h0}) begin
      failures++;
      $display("[TB] FAIL a_read_b_quiet got ack,err,stall=%b data=%h exp 001 0",
               {o_b_ack, o_b_err, o_b_stall}, o_b_data);
    end
    tick();
    i_wb_ack = 0; i_a_cyc = 0;
    #1;
    checks++;
    if (o_wb_cyc !== 1'b0) begin
      failures++;
      $display("[TB] FAIL a_read_release got cyc=%b exp=0", o_wb_cyc);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic exp_a;
    logic [2:0] exp_v;
    reset_dut();
    i_a_cyc = 1; i_b_cyc = 1;
    #1;
    checks++;
    if ({o_a_stall, o_b_stall, o_wb_cyc} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL rr_idle got=%b exp=110", {o_a_stall, o_b_stall, o_wb_cyc});
    end
    exp_a = 1'b1;
    for (int r = 0; r < 5; r++) begin
      exp_v = exp_a ? 3'b011 : 3'b101;
      for (int c = 0; c < 2; c++) begin
        tick();
        #1;
        checks++;
        if ({o_a_stall, o_b_stall, o_wb_cyc} !== exp_v) begin
          failures++;
          $display("[TB] FAIL rr_grant round=%0d cyc=%0d got=%b exp=%b", r, c,
                   {o_a_stall, o_b_stall, o_wb_cyc}, exp_v);
        end
      end
      tick();
      if (exp_a) i_a_cyc = 0;
      else       i_b_cyc = 0;
      #1;
      checks++;
      if (o_wb_cyc !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rr_drop round=%0d got cyc=%b exp=0", r, o_wb_cyc);
      end
      tick();
      i_a_cyc = 1; i_b_cyc = 1;
      #1;
      checks++;
      if ({o_a_stall, o_b_stall, o_wb_cyc} !== 3'b110) begin
        failures++;
        $display("[TB] FAIL rr_gap round=%0d got=%b exp=110", r, {o_a_stall, o_b_stall, o_wb_cyc});
      end
      exp_a = !exp_a;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_b_burst();
    logic [6:0] exp_stall;
    logic [9:0] ack_pat;
    int acks;
    exp_stall = 7'b001_0000;
    ack_pat   = 10'b11_1111_0000;
    acks = 0;
    reset_dut();
    i_b_cyc = 1; i_b_stb = 1; i_b_addr = 30'h40;
    #1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      i_b_stb = (k <= 7);
      i_wb_ack = ack_pat[k-1];
      i_wb_data = 32'h1000 + 32'(k);
      #1;
      if (k <= 7) begin
        checks++;
        if ({o_b_stall, o_wb_stb} !== {exp_stall[k-1], !exp_stall[k-1]}) begin
          failures++;
          $display("[TB] FAIL burst_stall k=%0d got stall,stb=%b exp=%b", k,
                   {o_b_stall, o_wb_stb}, {exp_stall[k-1], !exp_stall[k-1]});
        end
      end
      if (k == 5) begin
        checks++;
        if (o_b_data !== 32'h1005) begin
          failures++;
          $display("[TB] FAIL burst_data got=%h exp=00001005", o_b_data);
        end
      end
      if (o_b_ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 6) begin
      failures++;
      $display("[TB] FAIL burst_ack_count got=%0d exp=6", acks);
    end
    tick();
    i_wb_ack = 1;
    #1;
    checks++;
    if ({o_b_ack, o_b_stall} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL burst_drained got ack,stall=%b exp=00", {o_b_ack, o_b_stall});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_watchdog();
    int early;
    early = 0;
    reset_dut();
    i_a_cyc = 1; i_a_stb = 1; i_b_cyc = 1;
    tick();
    #1;
    checks++;
    if ({o_wb_stb, o_a_stall} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL wd_accept got stb,stall=%b exp=10", {o_wb_stb, o_a_stall});
    end
    for (int k = 2; k <= 16; k++) begin
      tick();
      if (k == 2) i_a_stb = 0;
      #1;
      if (o_a_err !== 1'b0 || o_wb_cyc !== 1'b1) early++;
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("[TB] FAIL wd_early got=%0d bad cycles exp=0", early);
    end
    tick();
    #1;
    checks++;
    if ({o_a_err, o_wb_cyc, o_a_stall, o_b_stall} !== 4'b1011) begin
      failures++;
      $display("[TB] FAIL wd_fire got err,cyc,astall,bstall=%b exp=1011",
               {o_a_err, o_wb_cyc, o_a_stall, o_b_stall});
    end
    tick();
    #1;
    checks++;
    if ({o_a_err, o_wb_cyc, o_a_stall, o_b_stall} !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL wd_drain got err,cyc,astall,bstall=%b exp=0011",
               {o_a_err, o_wb_cyc, o_a_stall, o_b_stall});
    end
    tick();
    tick();
    i_a_cyc = 0;
    #1;
    checks++;
    if ({o_b_stall, o_wb_cyc} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL wd_drain_exit got bstall,cyc=%b exp=10", {o_b_stall, o_wb_cyc});
    end
    tick();
    #1;
    checks++;
    if ({o_b_stall, o_wb_cyc} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL wd_idle got bstall,cyc=%b exp=10", {o_b_stall, o_wb_cyc});
    end
    tick();
    #1;
    checks++;
    if ({o_b_stall, o_wb_cyc} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL wd_b_grant got bstall,cyc=%b exp=01", {o_b_stall, o_wb_cyc});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_ack_err();
    reset_dut();
    i_a_cyc = 1; i_a_stb = 1;
    tick();
    tick();
    i_a_stb = 0; i_wb_ack = 1; i_wb_err = 1;
    #1;
    checks++;
    if ({o_a_ack, o_a_err} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL ack_err_both got ack,err=%b exp=01", {o_a_ack, o_a_err});
    end
    tick();
    i_wb_ack = 0; i_wb_err = 0; i_a_cyc = 0;
    tick();
    i_wb_ack = 1;
    #1;
    checks++;
    if ({o_a_ack, o_b_ack, o_a_err, o_b_err} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL stray_ack_idle got=%b exp=0000", {o_a_ack, o_b_ack, o_a_err, o_b_err});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    reset_dut();
    i_b_cyc = 1; i_b_stb = 1;
    tick();
    tick();
    tick();
    i_b_stb = 0;
    #1;
    i_reset = 1;
    #1;
    checks++;
    if ({o_wb_cyc, o_a_stall, o_b_stall} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL async_reset got cyc,astall,bstall=%b exp=011", {o_wb_cyc, o_a_stall, o_b_stall});
    end
    tick();
    i_reset = 0;
    i_b_cyc = 0;
    tick();
    i_a_cyc = 1; i_b_cyc = 1;
    tick();
    #1;
    checks++;
    if ({o_a_stall, o_b_stall, o_wb_cyc} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL post_reset_grant got astall,bstall,cyc=%b exp=011", {o_a_stall, o_b_stall, o_wb_cyc});
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    i_reset = 1'b1;
    test_reset();
    test_a_read();
    test_round_robin();
    test_b_burst();
    test_watchdog();
    test_ack_err();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
